// File: rtl/ysyx_22041071_rf_bypass_pkg.sv
// Shared parameters and helpers for the register-file / operand-bypass stage.
package ysyx_22041071_rf_bypass_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRD_DEF  = 2;
  localparam int unsigned NFWD_DEF = 3;
  localparam int unsigned CNTW_DEF = 32;

  // Register-index width; never below one bit so degenerate files still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_22041071_bypass_mux.sv
// Single-port operand selector: zero register, prioritised forwarding,
// write-back write-through, then register-array value.
module ysyx_22041071_bypass_mux
  import ysyx_22041071_rf_bypass_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5,
  parameter int unsigned NFWD = NFWD_DEF
) (
  input  logic [AW-1:0]        rs,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_avail,
  input  logic                 wb_wen,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [XLEN-1:0]      rf_data,
  output logic [XLEN-1:0]      data,
  output logic                 hit_unavail
);

  logic found;

  // Youngest matching forwarding source wins; an unavailable winner flags a
  // load-use hazard even if an older source could supply a value.
  always_comb begin
    data        = rf_data;
    hit_unavail = 1'b0;
    found       = 1'b0;
    if (rs == '0) begin
      data = '0;
    end else begin
      for (int j = 0; j < int'(NFWD); j++) begin
        if (!found && fwd_wen[j] && (fwd_addr[j*AW +: AW] == rs)) begin
          found       = 1'b1;
          data        = fwd_data[j*XLEN +: XLEN];
          hit_unavail = ~fwd_avail[j];
        end
      end
      if (!found && wb_wen && (wb_addr == rs)) begin
        data = wb_data;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041071_rf_bypass.sv
// Register file plus operand bypass with a registered valid/ready output slot,
// flush, load-use hazard detection and a saturating stall counter.
module ysyx_22041071_rf_bypass
  import ysyx_22041071_rf_bypass_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = NRD_DEF,
  parameter int unsigned NFWD = NFWD_DEF,
  parameter int unsigned CNTW = CNTW_DEF,
  localparam int unsigned AW  = idx_width(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NRD*AW-1:0]    rs_addr,
  input  logic [NRD-1:0]       rs_used,
  input  logic [AW-1:0]        dst_addr,
  input  logic                 dst_wen,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_avail,
  input  logic                 wb_wen,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NRD*XLEN-1:0]  out_rs_data,
  output logic [AW-1:0]        out_dst_addr,
  output logic                 out_dst_wen,
  output logic                 hazard,
  output logic [CNTW-1:0]      stall_cnt,
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  logic [XLEN-1:0]     rf [NREG];
  logic [XLEN-1:0]     rf_rd [NRD];
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      hit_unavail;
  logic                slot_free;
  logic                accept;

  // Register array; index 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(NREG); k++) begin
        rf[k] <= '0;
      end
    end else if (wb_wen && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // One priority selector per read port.
  for (genvar i = 0; i < int'(NRD); i++) begin : g_port
    assign rf_rd[i] = rf[rs_addr[i*AW +: AW]];

    ysyx_22041071_bypass_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .NFWD (NFWD)
    ) u_mux (
      .rs          (rs_addr[i*AW +: AW]),
      .fwd_wen     (fwd_wen),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .fwd_avail   (fwd_avail),
      .wb_wen      (wb_wen),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .rf_data     (rf_rd[i]),
      .data        (rs_data[i*XLEN +: XLEN]),
      .hit_unavail (hit_unavail[i])
    );
  end

  // Handshake: stall on a consumed operand whose selected source is not ready.
  always_comb begin
    hazard    = |(hit_unavail & rs_used);
    slot_free = !out_valid || out_ready;
    in_ready  = slot_free && !hazard;
    accept    = in_valid && in_ready;
  end

  // Debug port reads the array only; no bypass applied.
  assign dbg_data = rf[dbg_addr];

  // Output slot: flush beats accept; a free slot without accept becomes a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_rs_data  <= '0;
      out_dst_addr <= '0;
      out_dst_wen  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs_data  <= rs_data;
      out_dst_addr <= dst_addr;
      out_dst_wen  <= dst_wen;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was held by a hazard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_rf_bypass.sv
// Directed self-checking bench for ysyx_22041071_rf_bypass.
module tb_ysyx_22041071_rf_bypass;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NFWD = 3;
  localparam int unsigned CNTW = 32;
  localparam int unsigned AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD-1:0]       rs_used;
  logic [AW-1:0]        dst_addr;
  logic                 dst_wen;
  logic [NFWD-1:0]      fwd_wen;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_avail;
  logic                 wb_wen;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [NRD*XLEN-1:0]  out_rs_data;
  logic [AW-1:0]        out_dst_addr;
  logic                 out_dst_wen;
  logic                 hazard;
  logic [CNTW-1:0]      stall_cnt;
  logic [AW-1:0]        dbg_addr;
  logic [XLEN-1:0]      dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041071_rf_bypass #(
    .XLEN (XLEN), .NREG (NREG), .NRD (NRD), .NFWD (NFWD), .CNTW (CNTW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rs_addr      (rs_addr),
    .rs_used      (rs_used),
    .dst_addr     (dst_addr),
    .dst_wen      (dst_wen),
    .fwd_wen      (fwd_wen),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_avail    (fwd_avail),
    .wb_wen       (wb_wen),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs_data  (out_rs_data),
    .out_dst_addr (out_dst_addr),
    .out_dst_wen  (out_dst_wen),
    .hazard       (hazard),
    .stall_cnt    (stall_cnt),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    fwd_addr[j*AW +: AW]     = a;
    fwd_data[j*XLEN +: XLEN] = d;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; rs_addr = '0; rs_used = '0;
    dst_addr = '0; dst_wen = 1'b0; fwd_wen = '0; fwd_addr = '0;
    fwd_data = '0; fwd_avail = '1; flush = 1'b0; out_ready = 1'b1;
    wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD; dbg_addr = 5'd5;

    // Reset held two cycles with a competing write to reg5
    tick();
    tick();
    check("rst_dbg5", dbg_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_rs_data", out_rs_data, 0);

    // Write reg7 while idle
    reset = 1'b1; wb_addr = 5'd7; wb_data = 64'h1234; dbg_addr = 5'd7;
    tick();
    check("wb_reg7", dbg_data, 64'h1234);
    check("idle_bubble", out_valid, 0);

    // Array read on port0, write-through on port1
    wb_addr = 5'd8; wb_data = 64'hAA; in_valid = 1'b1;
    rs_addr = {5'd8, 5'd7}; rs_used = 2'b11; dst_addr = 5'd4; dst_wen = 1'b1;
    #1;
    check("accept_in_ready", in_ready, 1);
    tick();
    check("acc1_valid", out_valid, 1);
    check("acc1_data", out_rs_data, {64'hAA, 64'h1234});
    check("acc1_dst", {out_dst_wen, out_dst_addr}, {1'b1, 5'd4});

    // Two sources match: youngest wins; rs1=0 reads zero
    wb_wen = 1'b0; fwd_wen = 3'b011; set_fwd(0, 5'd9, 64'h11); set_fwd(1, 5'd9, 64'h22);
    rs_addr = {5'd0, 5'd9};
    tick();
    check("fwd_prio", out_rs_data, {64'h0, 64'h11});

    // Forwarding source targeting reg0 must not affect rs=0
    set_fwd(0, 5'd0, 64'h11); rs_addr = {5'd9, 5'd0};
    tick();
    check("fwd_zero", out_rs_data, {64'h22, 64'h0});

    // Load-use: youngest match unavailable, older available match does not clear it
    fwd_wen = 3'b011; set_fwd(0, 5'd10, 64'h0); set_fwd(1, 5'd10, 64'h99);
    fwd_avail = 3'b110; rs_addr = {5'd0, 5'd10}; rs_used = 2'b01;
    #1;
    check("lu_hazard", hazard, 1);
    check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_bubble", out_valid, 0);
    check("lu_stall_cnt", stall_cnt, 1);

    // Unused operand does not stall
    rs_used = 2'b10;
    #1;
    check("unused_no_hazard", hazard, 0);

    // Load result arrives
    rs_used = 2'b01; fwd_avail = 3'b111; set_fwd(0, 5'd10, 64'h55);
    dst_addr = 5'd12; dst_wen = 1'b1;
    #1;
    check("lu_resolved_ready", in_ready, 1);
    tick();
    check("lu_accept_valid", out_valid, 1);
    check("lu_accept_data", out_rs_data[63:0], 64'h55);
    check("lu_cnt_hold", stall_cnt, 1);

    // Backpressure for three cycles with changing forwarding data
    out_ready = 1'b0; fwd_wen = 3'b001; rs_addr = {5'd0, 5'd11}; dst_addr = 5'd13;
    for (int c = 0; c < 3; c++) begin
      set_fwd(0, 5'd11, 64'h60 + 64'(c));
      #1;
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_rs_data, {64'h0, 64'h55});
      check("bp_dst", out_dst_addr, 5'd12);
    end

    // Release and accept back-to-back
    out_ready = 1'b1; set_fwd(0, 5'd11, 64'h77);
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();
    check("b2b1_data", out_rs_data[63:0], 64'h77);
    check("b2b1_dst", out_dst_addr, 5'd13);
    set_fwd(0, 5'd11, 64'h88);
    tick();
    check("b2b2_valid", out_valid, 1);
    check("b2b2_data", out_rs_data[63:0], 64'h88);

    // Flush with concurrent accept and write-back
    flush = 1'b1; wb_wen = 1'b1; wb_addr = 5'd3; wb_data = 64'h9; dbg_addr = 5'd3;
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_wb", dbg_data, 64'h9);

    // Reset beats flush and accept; stall counter cleared
    flush = 1'b0; wb_wen = 1'b0; reset = 1'b0;
    tick();
    check("rst2_valid", out_valid, 0);
    check("rst2_reg3", dbg_data, 0);
    check("rst2_cnt", stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_rf_bypass.md
Name: ysyx_22041071_rf_bypass

Overview:
Parametrised register-file and operand-bypass stage for the ysyx_22041071 in-order RISC-V pipeline; it replaces the fixed 2-read, 3-source forwarding logic inside the decode stage.
- NRD read ports, NFWD prioritised forwarding sources, per-source data-availability flag for generic load-use detection.
- Registered output slot with valid/ready handshake, flush, saturating stall counter.
- Single debug read port instead of 32 flat register outputs.

Parameters:
XLEN, 64, datapath width
NREG, 32, architectural registers (index width AW = clog2(NREG)); register 0 hard-wired zero
NRD, 2, read ports
NFWD, 3, forwarding sources; index 0 = youngest (EX), highest priority
CNTW, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low; sampled at posedge clk, 0 = reset
in_valid  in  1  upstream decode has an instruction
in_ready  out  1  stage accepts this cycle
rs_addr  in  NRD*AW  source register indices, port i at [i*AW +: AW]
rs_used  in  NRD  port i operand is actually consumed
dst_addr  in  AW  destination register, carried through
dst_wen  in  1  destination write enable, carried through
fwd_wen  in  NFWD  source j will write a register
fwd_addr  in  NFWD*AW  source j destination
fwd_data  in  NFWD*XLEN  source j result
fwd_avail  in  NFWD  source j data valid now (0 = load still in flight)
wb_wen  in  1  register-file write enable
wb_addr  in  AW  write index
wb_data  in  XLEN  write data
flush  in  1  kill accepted and held instruction
out_valid  out  1  output slot holds an instruction
out_ready  in  1  downstream (EX) accepts
out_rs_data  out  NRD*XLEN  resolved operands
out_dst_addr  out  AW  registered dst_addr
out_dst_wen  out  1  registered dst_wen
hazard  out  1  load-use stall this cycle (combinational)
stall_cnt  out  CNTW  cycles with in_valid && hazard
dbg_addr  in  AW  debug read index
dbg_data  out  XLEN  reg[dbg_addr] (combinational, array only, no bypass)

Behaviour:
- Reset (reset==0 at posedge): all registers 0; out_valid 0; out_rs_data 0; out_dst_addr 0; out_dst_wen 0; stall_cnt 0. Reset wins over wb write, accept and flush in the same cycle. In-flight output is dropped.
- Register write: on posedge, if reset==1, wb_wen and wb_addr!=0, then reg[wb_addr] <= wb_data. Writes to reg 0 are ignored; reg 0 always reads 0.
- Operand resolution, per port i, combinational:
  - rs==0: result 0.
  - Otherwise, lowest j with fwd_wen[j] and fwd_addr[j]==rs: result fwd_data[j].
  - Otherwise, wb_wen and wb_addr==rs: result wb_data (write-through).
  - Otherwise: result reg[rs].
- Hazard: set when some port i has rs_used[i], rs!=0, and the selected source is j with fwd_avail[j]==0. A lower-priority available match does not clear it.
- Handshake:
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && !hazard.
  - Accept = in_valid && in_ready: out_valid <= 1; operands and dst fields are latched.
  - slot_free && !accept: out_valid <= 0 (bubble). This covers both the hazard case and in_valid==0.
  - out_valid && !out_ready: all outputs hold, regardless of forwarding changes. Latency is 1 cycle from accept.
- Flush: at posedge, out_valid <= 0 and any concurrent accept is discarded. Flush beats accept; reset beats flush. Flush does not block the register write.
- stall_cnt: increments when in_valid && hazard, saturates at all-ones, and is cleared only by reset.
- Operands are sampled only at accept; the held slot never re-resolves.

Decomposition:
- Shared define file: AW derivation macro, ysyx_22041071_DATA_BUS width, and opcode constants already used by decode. There are no new typedefs.
- One natural sub-module, ysyx_22041071_bypass_mux: a single-port priority selector (rs, fwd vectors, wb, array value → data, hit_unavail), instantiated NRD times via generate.
- The register array, output slot and counter stay in the top.

Test Plan:
- Reset held low 2 cycles with wb_wen=1, wb_addr=5 → reg5 stays 0; dbg_addr=5 gives 0; out_valid 0; stall_cnt 0.
- wb write reg7=0x1234, next cycle rs0=7, fwd_wen=0, accept → out_rs_data port0=0x1234. Same-cycle write reg8=0xAA with rs1=8 → 0xAA (write-through).
- fwd_wen=3'b011, fwd_addr[0]=fwd_addr[1]=9, fwd_data0=0x11, fwd_data1=0x22, all avail → port0=0x11. Then rs=0 with fwd_addr[0]=0 → 0.
- Load-use: fwd_addr[0]=10, fwd_avail[0]=0, rs0=10, rs_used=1 → hazard=1, in_ready=0, bubble (out_valid 0), stall_cnt +1. Next cycle avail=1, data 0x55 → accept, port0=0x55.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while forwarding data changes → outputs constant, in_ready=0. Then out_ready=1 with a new in_valid → back-to-back accept.
- Flush asserted concurrently with accept → out_valid 0 next cycle. Concurrent wb write reg3=0x9 is still performed.
